// File: rtl/bresenham_ray_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : bresenham_ray_scheduler_if
//  Brief    : Ray request / cell stream bundle for the Bresenham ray scheduler.
//             master = ray source + cell sink, slave = scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface bresenham_ray_scheduler_if #(
  parameter int COORD_W = 16,
  parameter int DELTA_W = 12
);
  // ray request channel
  logic               ray_valid;
  logic               ray_ready;
  logic [COORD_W-1:0] origin_x;
  logic [COORD_W-1:0] origin_y;
  logic [DELTA_W-1:0] dx;
  logic [DELTA_W-1:0] dy;
  logic               flip_x;
  logic               flip_y;
  logic               flip_identity;

  // cell output channel
  logic               cell_valid;
  logic               cell_ready;
  logic [COORD_W-1:0] cell_x;
  logic [COORD_W-1:0] cell_y;
  logic               cell_last;

  // status
  logic               bad_ray;

  modport master (
    output ray_valid, origin_x, origin_y, dx, dy, flip_x, flip_y, flip_identity,
    output cell_ready,
    input  ray_ready, cell_valid, cell_x, cell_y, cell_last, bad_ray
  );

  modport slave (
    input  ray_valid, origin_x, origin_y, dx, dy, flip_x, flip_y, flip_identity,
    input  cell_ready,
    output ray_ready, cell_valid, cell_x, cell_y, cell_last, bad_ray
  );
endinterface
`default_nettype wire

// File: rtl/bresenham_ray_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bresenham_ray_scheduler
//  Brief    : Walks one octant-0 Bresenham ray per request, one cell per
//             cycle, and maps each step back to the true octant before
//             streaming absolute map cells to the occupancy-grid updater.
//             COORD_W must be larger than DELTA_W.
//  Revision : 1.0  initial release
// ============================================================================
module bresenham_ray_scheduler #(
  parameter int COORD_W = 16,
  parameter int DELTA_W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  bresenham_ray_scheduler_if.slave    bus
);

  localparam int D_W = DELTA_W + 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // latched ray description
  logic [COORD_W-1:0] org_x;
  logic [COORD_W-1:0] org_y;
  logic [DELTA_W-1:0] len_dx;
  logic [DELTA_W-1:0] len_dy;
  logic               neg_x;
  logic               neg_y;
  logic               swap_xy;

  // walk state
  logic [DELTA_W-1:0]    u;
  logic [DELTA_W-1:0]    v;
  logic signed [D_W-1:0] d;
  logic                  bad_pulse;

  logic                  accept;
  logic                  handshake;
  logic                  at_end;
  logic [DELTA_W-1:0]    dy_clamped;
  logic signed [D_W-1:0] d_init;
  logic signed [D_W-1:0] two_dy;
  logic signed [D_W-1:0] two_dx;
  logic                  d_positive;

  logic [DELTA_W-1:0] a_mag;
  logic [DELTA_W-1:0] b_mag;
  logic [COORD_W-1:0] a_ext;
  logic [COORD_W-1:0] b_ext;
  logic [COORD_W-1:0] a_off;
  logic [COORD_W-1:0] b_off;

  assign accept     = bus.ray_valid && (state == IDLE);
  assign handshake  = (state == STEP) && bus.cell_ready;
  assign at_end     = (u == len_dx);

  // A too-steep request is folded onto the diagonal rather than rejected.
  assign dy_clamped = (bus.dy > bus.dx) ? bus.dx : bus.dy;
  assign d_init     = $signed({1'b0, dy_clamped, 1'b0}) - $signed({2'b00, bus.dx});

  assign two_dy     = $signed({1'b0, len_dy, 1'b0});
  assign two_dx     = $signed({1'b0, len_dx, 1'b0});
  assign d_positive = !d[D_W-1] && (d != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_next     = state;
    bus.ray_ready  = 1'b0;
    bus.cell_valid = 1'b0;
    bus.cell_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.ray_ready = 1'b1;
        if (bus.ray_valid) begin
          state_next = STEP;
        end
      end
      STEP: begin
        bus.cell_valid = 1'b1;
        bus.cell_last  = at_end;
        if (bus.cell_ready && at_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ray latch and Bresenham walk: advance only on an accepted cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      org_x     <= '0;
      org_y     <= '0;
      len_dx    <= '0;
      len_dy    <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
      swap_xy   <= 1'b0;
      u         <= '0;
      v         <= '0;
      d         <= '0;
      bad_pulse <= 1'b0;
    end else begin
      bad_pulse <= accept && (bus.dy > bus.dx);
      if (accept) begin
        org_x   <= bus.origin_x;
        org_y   <= bus.origin_y;
        len_dx  <= bus.dx;
        len_dy  <= dy_clamped;
        neg_x   <= bus.flip_x;
        neg_y   <= bus.flip_y;
        swap_xy <= bus.flip_identity;
        u       <= '0;
        v       <= '0;
        d       <= d_init;
      end else if (handshake && !at_end) begin
        u <= u + 1'b1;
        if (d_positive) begin
          v <= v + 1'b1;
          d <= d + two_dy - two_dx;
        end else begin
          d <= d + two_dy;
        end
      end
    end
  end

  // Octant mapping: optional axis swap, then per-axis negation, then offset
  // from the origin with natural two's complement wrap.
  always_comb begin
    a_mag = swap_xy ? v : u;
    b_mag = swap_xy ? u : v;
    a_ext = {{(COORD_W-DELTA_W){1'b0}}, a_mag};
    b_ext = {{(COORD_W-DELTA_W){1'b0}}, b_mag};
    a_off = neg_x ? -a_ext : a_ext;
    b_off = neg_y ? -b_ext : b_ext;
    bus.cell_x  = org_x + a_off;
    bus.cell_y  = org_y + b_off;
    bus.bad_ray = bad_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_bresenham_ray_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bresenham_ray_scheduler
//  Brief    : Directed and randomized bench for bresenham_ray_scheduler with
//             a closed-form line model (rounded slope, ties toward the axis).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bresenham_ray_scheduler;

  localparam int COORD_W = 16;
  localparam int DELTA_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  bresenham_ray_scheduler_if #(.COORD_W(COORD_W), .DELTA_W(DELTA_W)) bus ();

  bresenham_ray_scheduler #(.COORD_W(COORD_W), .DELTA_W(DELTA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected cell at step u: minor coordinate is u*dy/dx rounded to nearest,
  // exact halves rounded toward the major axis.
  function automatic void model(input logic [15:0] ox, input logic [15:0] oy,
                                input int dxi, input int dyc,
                                input bit fx, input bit fy, input bit fi,
                                input int u,
                                output logic [15:0] ex, output logic [15:0] ey);
    int vv;
    int a;
    int b;
    int t;
    vv = (dxi == 0) ? 0 : (2 * u * dyc + dxi - 1) / (2 * dxi);
    a = u;
    b = vv;
    if (fi) begin
      t = a; a = b; b = t;
    end
    if (fx) a = -a;
    if (fy) b = -b;
    ex = 16'(int'(ox) + a);
    ey = 16'(int'(oy) + b);
  endfunction

  // mode: 0 ready always, 1 ready toggling 1,0,..., 2 random ready.
  // stop_at >= 0 returns after that many cell handshakes (for abort tests).
  task automatic run_ray(input logic [15:0] ox, input logic [15:0] oy,
                         input int dxi, input int dyi,
                         input bit fx, input bit fy, input bit fi,
                         input int mode, input int stop_at);
    int dyc;
    int n;
    int idx;
    int cyc;
    bit rdy;
    logic [15:0] ex;
    logic [15:0] ey;
    dyc = (dyi > dxi) ? dxi : dyi;
    n   = dxi + 1;
    cyc = 0;
    while (bus.ray_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ray_ready_before_accept", {31'd0, bus.ray_ready}, 32'd1);
    bus.origin_x      = ox;
    bus.origin_y      = oy;
    bus.dx            = 12'(dxi);
    bus.dy            = 12'(dyi);
    bus.flip_x        = fx;
    bus.flip_y        = fy;
    bus.flip_identity = fi;
    bus.ray_valid     = 1'b1;
    @(negedge clk);
    // Inputs after the accept cycle must have no effect.
    bus.ray_valid     = 1'b0;
    bus.origin_x      = 16'($urandom);
    bus.origin_y      = 16'($urandom);
    bus.dx            = 12'($urandom);
    bus.dy            = 12'($urandom);
    bus.flip_x        = 1'($urandom);
    bus.flip_y        = 1'($urandom);
    bus.flip_identity = 1'($urandom);
    check("bad_ray_pulse", {31'd0, bus.bad_ray}, {31'd0, (dyi > dxi)});
    idx = 0;
    cyc = 0;
    while (idx < n) begin
      if (stop_at >= 0 && idx == stop_at) return;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      bus.cell_ready = rdy;
      model(ox, oy, dxi, dyc, fx, fy, fi, idx, ex, ey);
      check("cell_valid", {31'd0, bus.cell_valid}, 32'd1);
      check("ray_ready_busy", {31'd0, bus.ray_ready}, 32'd0);
      check("cell_x", {16'd0, bus.cell_x}, {16'd0, ex});
      check("cell_y", {16'd0, bus.cell_y}, {16'd0, ey});
      check("cell_last", {31'd0, bus.cell_last}, {31'd0, (idx == dxi)});
      if (cyc == 1) check("bad_ray_one_cycle", {31'd0, bus.bad_ray}, 32'd0);
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
      if (cyc > 20 * n + 20) begin
        tests++;
        fails++;
        $display("FAIL cell_timeout: handshakes=%0d required=%0d", idx, n);
        break;
      end
    end
    bus.cell_ready = 1'b1;
    check("cell_valid_after_ray", {31'd0, bus.cell_valid}, 32'd0);
    check("ray_ready_after_ray", {31'd0, bus.ray_ready}, 32'd1);
  endtask

  initial begin
    int rdx;
    int rdy_len;
    bus.ray_valid     = 1'b0;
    bus.origin_x      = '0;
    bus.origin_y      = '0;
    bus.dx            = '0;
    bus.dy            = '0;
    bus.flip_x        = 1'b0;
    bus.flip_y        = 1'b0;
    bus.flip_identity = 1'b0;
    bus.cell_ready    = 1'b1;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cell_valid", {31'd0, bus.cell_valid}, 32'd0);
    check("rst_cell_last", {31'd0, bus.cell_last}, 32'd0);
    check("rst_bad_ray", {31'd0, bus.bad_ray}, 32'd0);
    check("rst_cell_x", {16'd0, bus.cell_x}, 32'd0);
    check("rst_cell_y", {16'd0, bus.cell_y}, 32'd0);
    check("rst_ray_ready", {31'd0, bus.ray_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic octant-0 ray
    run_ray(16'd10, 16'd20, 4, 2, 1'b0, 1'b0, 1'b0, 0, -1);
    // 2: swapped axes, negated x
    run_ray(16'd10, 16'd20, 4, 2, 1'b1, 1'b0, 1'b1, 0, -1);
    // 3: toggling backpressure
    run_ray(16'd10, 16'd20, 4, 2, 1'b0, 1'b0, 1'b0, 1, -1);
    // 4: zero-length ray at a negative origin
    run_ray(16'hFFFD, 16'd7, 0, 0, 1'b0, 1'b0, 1'b0, 0, -1);

    // 5: reset after the second cell
    run_ray(16'd10, 16'd20, 4, 2, 1'b0, 1'b0, 1'b0, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cell_valid", {31'd0, bus.cell_valid}, 32'd0);
    check("abort_cell_x", {16'd0, bus.cell_x}, 32'd0);
    rst = 1'b0;
    check("abort_ray_ready", {31'd0, bus.ray_ready}, 32'd1);
    run_ray(16'd100, 16'd200, 3, 1, 1'b0, 1'b1, 1'b0, 0, -1);

    // 6: steep request folded to a diagonal, wrapping past 0x7FFF
    run_ray(16'h7FFF, 16'd0, 2, 5, 1'b0, 1'b0, 1'b0, 0, -1);

    // randomized rays with random backpressure
    for (int k = 0; k < 40; k++) begin
      rdx = int'($urandom_range(0, 30));
      if ($urandom_range(0, 7) == 0) rdy_len = rdx + int'($urandom_range(1, 5));
      else                           rdy_len = int'($urandom_range(0, rdx));
      run_ray(16'($urandom), 16'($urandom), rdx, rdy_len,
              1'($urandom), 1'($urandom), 1'($urandom),
              (k % 3 == 0) ? 0 : 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
